mem_image_loader: RTL and testbench

- Initiator side of the data-memory byte-load interface.
- Accepts a program/data image as 32-bit words over a valid/ready stream.
- Serialises each word into bytes and drives one load strobe plus one store byte per cycle.
- Holds ready low while loading and raises it when the image is complete, releasing the memory to the CPU.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_byte_shifter.sv | 59 +++++
 rtl/mem_image_loader.sv | 175 +++++++++++++++++
 tb/tb_mem_image_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the memory image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_byte_shifter.sv
// ============================================================================
// Module      : loader_byte_shifter
// Description : Holds one image word and presents it one byte at a time,
//               lowest or highest byte first depending on BIG_ENDIAN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_byte_shifter
    import loader_pkg::*;
#(
    parameter int BIG_ENDIAN = 0,
    parameter int WORD_W     = BYTES_PER_WORD * BYTE_W,
    parameter int IDX_W      = $clog2(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift,
    output logic [BYTE_W-1:0] o_byte,
    output logic [IDX_W-1:0]  o_byte_idx
);

    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] w_shifted;

    // The byte on o_byte is always the one at the "head" end of the register.
    generate
        if (BIG_ENDIAN != 0) begin : g_big
            assign o_byte    = r_word[WORD_W-1 -: BYTE_W];
            assign w_shifted = {r_word[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        end else begin : g_little
            assign o_byte    = r_word[BYTE_W-1:0];
            assign w_shifted = {{BYTE_W{1'b0}}, r_word[WORD_W-1:BYTE_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_word <= w_shifted;
            r_idx  <= r_idx + c_idx_one;
        end
    end

    assign o_byte_idx = r_idx;

endmodule

`default_nettype wire

// File: rtl/mem_image_loader.sv
// ============================================================================
// Module      : mem_image_loader
// Description : Streams a 32-bit word image into data memory one byte per
//               cycle, then releases the memory to the CPU.
//               Optional: LOADER_CHECKSUM_EN adds an 8-bit running byte sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_image_loader
    import loader_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   byte_count,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              load,
    output logic [7:0]        store,
    output logic [ADDR_W-1:0] load_addr,
    output logic              ready,
    output logic              busy,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic              done
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(BYTES_PER_WORD - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ready;
    logic              r_busy;
    logic [7:0]        r_store;
    logic              w_start_ok;
    logic [ADDR_W:0]   w_count;
    logic              w_word_ready;
    logic              w_load;
    logic              w_done;
    logic [7:0]        w_byte;
    logic [IDX_W-1:0]  w_byte_idx;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_count    = (byte_count > c_depth) ? c_depth : byte_count;

    loader_byte_shifter #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_word_ready && word_valid),
        .i_word     (word_in),
        .i_shift    (w_load),
        .o_byte     (w_byte),
        .o_byte_idx (w_byte_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (w_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                // A short final word ends the image before its last byte slot.
                if (r_remaining == c_cnt_one) begin
                    w_state_next = DONE;
                end else if (w_byte_idx == c_idx_last) begin
                    w_state_next = FETCH;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_word_ready = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            FETCH:   w_word_ready = 1'b1;
            EMIT:    w_load       = 1'b1;
            DONE:    w_done       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_addr      <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_store     <= '0;
        end else begin
            if (w_start_ok) begin
                r_remaining <= w_count;
                r_addr      <= '0;
                r_ready     <= 1'b0;
            end else if (w_load) begin
                r_remaining <= r_remaining - c_cnt_one;
                r_addr      <= r_addr + c_addr_one;
            end
            if (r_state == DONE) begin
                r_ready <= 1'b1;
            end
            r_busy <= (w_state_next == FETCH) || (w_state_next == EMIT);
            if (w_load) begin
                r_store <= w_byte;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_load) begin
            r_checksum <= r_checksum + w_byte;
        end
    end

    assign checksum = r_checksum;
`endif

    // store shows the live byte during a strobe and holds it afterwards.
    assign store      = w_load ? w_byte : r_store;
    assign word_ready = w_word_ready;
    assign load       = w_load;
    assign load_addr  = r_addr;
    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_image_loader.sv
// ============================================================================
// Module      : tb_mem_image_loader
// Description : Directed self-checking bench; little- and big-endian loaders
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_image_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   byte_count = '0;
    logic [31:0]       word_in = '0;
    logic              word_valid = 1'b0;

    logic              le_word_ready, le_load, le_ready, le_busy, le_done;
    logic [7:0]        le_store;
    logic [ADDR_W-1:0] le_load_addr;
    logic              be_word_ready, be_load, be_ready, be_busy, be_done;
    logic [7:0]        be_store;
    logic [ADDR_W-1:0] be_load_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        le_checksum, be_checksum;
`endif

    always #5 clk = ~clk;

    mem_image_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_count(byte_count),
        .word_in(word_in), .word_valid(word_valid), .word_ready(le_word_ready),
        .load(le_load), .store(le_store), .load_addr(le_load_addr),
        .ready(le_ready), .busy(le_busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum(le_checksum),
`endif
        .done(le_done)
    );

    mem_image_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_count(byte_count),
        .word_in(word_in), .word_valid(word_valid), .word_ready(be_word_ready),
        .load(be_load), .store(be_store), .load_addr(be_load_addr),
        .ready(be_ready), .busy(be_busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum(be_checksum),
`endif
        .done(be_done)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_done  = 0;
    int         n_wr    = 0;
    logic [7:0] q_le[$];
    logic [7:0] q_be[$];
    int         q_addr[$];
    int         q_cyc[$];
    int         q_hs[$];

    // Strobe/handshake recorder, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (le_load) begin
                q_le.push_back(le_store);
                q_addr.push_back(int'(le_load_addr));
                q_cyc.push_back(cyc);
            end
            if (be_load) q_be.push_back(be_store);
            if (le_done) n_done++;
            if (le_word_ready) begin
                n_wr++;
                if (word_valid) q_hs.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input bit use_be, input logic [63:0] exp, input int n);
        int         sz;
        logic [7:0] got;
        sz = use_be ? q_be.size() : q_le.size();
        check({tag, "_count"}, sz, n);
        for (int i = 0; i < n; i++) begin
            if (i < sz) got = use_be ? q_be[i] : q_le[i];
            else        got = 'x;
            check($sformatf("%s[%0d]", tag, i), {24'h0, got}, {24'h0, exp[8*i +: 8]});
        end
    endtask

    task automatic clear_mon();
        q_le.delete(); q_be.delete(); q_addr.delete(); q_cyc.delete(); q_hs.delete();
        n_done = 0;
        n_wr   = 0;
    endtask

    task automatic do_start(input int c);
        @(posedge clk); #1;
        start      = 1'b1;
        byte_count = c[ADDR_W:0];
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        t          = 0;
        word_in    = w;
        word_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!le_word_ready && t < 50);
        if (!le_word_ready) check("word_ready_timeout", {31'h0, le_word_ready}, 32'h1);
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        while (!le_done && t < bound) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'h0, le_done}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_ready", {31'h0, le_word_ready}, 32'h0);
        check("rst_load",       {31'h0, le_load},       32'h0);
        check("rst_store",      {24'h0, le_store},      32'h0);
        check("rst_load_addr",  {22'h0, le_load_addr},  32'h0);
        check("rst_ready",      {31'h0, le_ready},      32'h0);
        check("rst_busy",       {31'h0, le_busy},       32'h0);
        check("rst_done",       {31'h0, le_done},       32'h0);
        rst_n = 1'b1;

        // Two full words, presented immediately
        clear_mon();
        do_start(8);
        check("t1_busy_on",   {31'h0, le_busy},  32'h1);
        check("t1_ready_off", {31'h0, le_ready}, 32'h0);
        send_word(32'h44332211);
        send_word(32'h88776655);
        wait_done(20);
        check_bytes("t1_le", 1'b0, 64'h8877665544332211, 8);
        check_bytes("t1_be", 1'b1, 64'h5566778811223344, 8);
        for (int i = 0; i < 8; i++)
            if (i < q_addr.size()) check($sformatf("t1_addr[%0d]", i), q_addr[i], i);
        if (q_cyc.size() == 8 && q_hs.size() == 2) begin
            check("t1_first_latency", q_cyc[0], q_hs[0] + 1);
            check("t1_burst1_end",    q_cyc[3], q_hs[0] + 4);
            check("t1_word_spacing",  q_hs[1],  q_hs[0] + 5);
            check("t1_burst2_start",  q_cyc[4], q_hs[1] + 1);
            check("t1_burst2_end",    q_cyc[7], q_cyc[4] + 3);
        end else begin
            check("t1_strobe_hs_sizes", q_cyc.size() * 16 + q_hs.size(), 8 * 16 + 2);
        end
        check("t1_done_pulses", n_done, 1);
        check("t1_ready_after", {31'h0, le_ready}, 32'h1);
        check("t1_busy_after",  {31'h0, le_busy},  32'h0);
`ifdef LOADER_CHECKSUM_EN
        check("t1_checksum", {24'h0, le_checksum}, 32'h64);
`endif

        // Partial final word
        clear_mon();
        do_start(6);
        send_word(32'hDDCCBBAA);
        send_word(32'h0000FF11);
        wait_done(20);
        check_bytes("t2_le", 1'b0, 64'h0000FF11DDCCBBAA, 6);
        check_bytes("t2_be", 1'b1, 64'h00000000AABBCCDD, 6);
        check("t2_words", n_wr, 2);

        // Byte order on a single word
        clear_mon();
        do_start(4);
        send_word(32'h01020304);
        wait_done(20);
        check_bytes("t3_be", 1'b1, 64'h04030201, 4);
        check_bytes("t3_le", 1'b0, 64'h01020304, 4);
`ifdef LOADER_CHECKSUM_EN
        check("t3_checksum", {24'h0, le_checksum}, 32'h0A);
`endif

        // Withheld word, then a start pulse during EMIT
        clear_mon();
        do_start(4);
        repeat (10) @(posedge clk);
        #1;
        check("t4_wr_held",    n_wr, 10);
        check("t4_no_strobes", q_le.size(), 0);
        check("t4_wr_still",   {31'h0, le_word_ready}, 32'h1);
        send_word(32'h44332211);
        start      = 1'b1;
        byte_count = 11'd8;
        @(posedge clk); #1;
        start      = 1'b0;
        wait_done(20);
        repeat (3) @(posedge clk);
        #1;
        check_bytes("t4_le", 1'b0, 64'h44332211, 4);
        check("t4_done_pulses", n_done, 1);
        check("t4_ready", {31'h0, le_ready}, 32'h1);
`ifdef LOADER_CHECKSUM_EN
        check("t4_checksum_le", {24'h0, le_checksum}, 32'hAA);
        check("t4_checksum_be", {24'h0, be_checksum}, 32'hAA);
`endif

        // Zero-length image
        clear_mon();
        do_start(0);
        wait_done(2);
        check("t5_no_strobes", q_le.size(), 0);
        check("t5_no_wr",      n_wr, 0);
        check("t5_done_pulses", n_done, 1);
        check("t5_ready",      {31'h0, le_ready}, 32'h1);
`ifdef LOADER_CHECKSUM_EN
        check("t5_checksum", {24'h0, le_checksum}, 32'h0);
`endif

        // Oversized count clamps to DEPTH
        clear_mon();
        do_start(2000);
        for (int w = 0; w < DEPTH / 4; w++) begin
            logic [7:0] b0;
            b0 = 8'(w * 4);
            send_word({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end
        wait_done(20);
        check("t5_clamp_strobes", q_le.size(), DEPTH);
        check("t5_clamp_words",   n_wr, DEPTH / 4);
        check("t5_clamp_done",    n_done, 1);
        if (q_le.size() == DEPTH) begin
            check("t5_clamp_last_addr", q_addr[DEPTH-1], DEPTH - 1);
            check("t5_clamp_last_byte", {24'h0, q_le[DEPTH-1]}, 32'hFF);
        end

        // Reset in the middle of EMIT
        clear_mon();
        do_start(8);
        send_word(32'h11223344);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_load_off",  {31'h0, le_load},  32'h0);
        check("t6_ready_off", {31'h0, le_ready}, 32'h0);
        check("t6_busy_off",  {31'h0, le_busy},  32'h0);
        check("t6_store_off", {24'h0, le_store}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_strobes", q_le.size(), 0);
        check("t6_no_wr",      n_wr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
